// File: rtl/tns_encoder_pipe.sv
// Pipelined Fibonacci-weighted TNS encoder with per-group leading-bit hysteresis.
// An entry register feeds S compute stages; one global enable stalls the whole pipe.
module tns_encoder_pipe #(
    parameter int unsigned NGROUP = 8,
    parameter int unsigned DIN_W  = 17,
    parameter int unsigned GPS    = 2
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic [DIN_W-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  hys_en,
    input  logic                  hys_clr,
    output logic [3*NGROUP-1:0]   code_out,
    output logic                  out_valid,
    input  logic                  out_ready
);

    function automatic longint unsigned fib(input int unsigned n);
        longint unsigned a, b, t;
        a = 0;
        b = 1;
        for (int unsigned i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    localparam int unsigned     CW   = 3 * NGROUP;
    localparam int unsigned     S    = (NGROUP + GPS - 1) / GPS;
    localparam longint unsigned FTOP = fib(CW + 3);
    localparam int unsigned     RW   = $clog2(FTOP);

    function automatic logic [CW*RW-1:0] wtab();
        logic [CW*RW-1:0] t;
        t = '0;
        for (int unsigned k = 0; k < CW; k++)
            t[k*RW +: RW] = RW'(fib(k + 2));
        return t;
    endfunction

    localparam logic [CW*RW-1:0] WTAB = wtab();

    if (((64'd1 << DIN_W) - 64'd1) > (FTOP - 64'd2)) begin : g_din_w_check
        $error("tns_encoder_pipe: DIN_W too wide for NGROUP code groups");
    end
    if (GPS == 0) begin : g_gps_check
        $error("tns_encoder_pipe: GPS must be at least 1");
    end

    // res_q/hen_q/vld_q[s] feed stage s; code_q[s] holds stage s result.
    logic [RW-1:0]     res_q  [0:S-1];
    logic              hen_q  [0:S-1];
    logic              vld_q  [0:S];
    logic [CW-1:0]     code_q [0:S-1];
    logic [RW-1:0]     res_d  [0:S-1];
    logic [CW-1:0]     code_d [0:S-1];
    logic [NGROUP-1:0] hist;
    logic              en;

    logic [RW-1:0]     r_t, a_t, b_t, w_c;
    logic [CW-1:0]     c_t;
    logic              lead;
    int unsigned       g;

    assign en        = !vld_q[S] || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_q[S];
    assign code_out  = code_q[S-1];

    always_comb begin
        r_t  = '0;
        a_t  = '0;
        b_t  = '0;
        w_c  = '0;
        c_t  = '0;
        lead = 1'b0;
        g    = 0;
        for (int unsigned s = 0; s < S; s++) begin
            r_t = res_q[s];
            if (s > 0) c_t = code_q[s-1];
            else       c_t = '0;
            for (int unsigned j = 0; j < GPS; j++) begin
                if (s * GPS + j < NGROUP) begin
                    g   = NGROUP - 1 - (s * GPS + j);
                    a_t = WTAB[(3*g+2)*RW +: RW];
                    b_t = WTAB[(3*g+1)*RW +: RW];
                    w_c = WTAB[(3*g)*RW +: RW];
                    // Window [A, A+C) is where either leading bit still encodes r.
                    if (r_t < a_t)             lead = 1'b0;
                    else if (r_t >= a_t + w_c) lead = 1'b1;
                    else                       lead = hen_q[s] ? hist[g] : 1'b1;
                    c_t[3*g+2] = lead;
                    if (lead) r_t = r_t - a_t;
                    if (r_t >= b_t) begin
                        c_t[3*g+1] = 1'b1;
                        r_t = r_t - b_t;
                    end
                    if (r_t >= w_c) begin
                        c_t[3*g] = 1'b1;
                        r_t = r_t - w_c;
                    end
                end
            end
            res_d[s]  = r_t;
            code_d[s] = c_t;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < S; s++) begin
                res_q[s]  <= '0;
                hen_q[s]  <= 1'b0;
                code_q[s] <= '0;
            end
            for (int unsigned s = 0; s <= S; s++)
                vld_q[s] <= 1'b0;
        end else if (en) begin
            res_q[0] <= RW'(in_data);
            hen_q[0] <= hys_en;
            vld_q[0] <= in_valid;
            for (int unsigned s = 1; s < S; s++) begin
                res_q[s] <= res_d[s-1];
                hen_q[s] <= hen_q[s-1];
            end
            for (int unsigned s = 0; s < S; s++) begin
                code_q[s]  <= code_d[s];
                vld_q[s+1] <= vld_q[s];
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
        end else if (hys_clr) begin
            hist <= '0;
        end else if (en) begin
            for (int unsigned gi = 0; gi < NGROUP; gi++)
                if (vld_q[(NGROUP-1-gi)/GPS])
                    hist[gi] <= code_d[(NGROUP-1-gi)/GPS][3*gi+2];
        end
    end

endmodule

// File: tb/tb_tns_encoder_pipe.sv
// Scoreboard bench for tns_encoder_pipe (NGROUP=2, GPS=1, DIN_W=5): driver pushes
// expected codewords, a negedge monitor pops and checks outputs, stalls and latency.
module tb_tns_encoder_pipe;

    localparam int NG = 2;
    localparam int DW = 5;
    localparam int CW = 3 * NG;

    logic          clock;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          hys_en;
    logic          hys_clr;
    logic [CW-1:0] code_out;
    logic          out_valid;
    logic          out_ready;

    tns_encoder_pipe #(.NGROUP(NG), .DIN_W(DW), .GPS(1)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .hys_en    (hys_en),
        .hys_clr   (hys_clr),
        .code_out  (code_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [CW-1:0] exp;
        int            din;
        int            acc;
        bit            chk_lat;
    } item_t;

    item_t         sbq[$];
    item_t         mon_it;
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            wt[0:CW-1];
    bit            mh[0:NG-1];
    bit            stall_prev = 0;
    logic [CW-1:0] prev_code;
    int            wsum;
    bit            rdone;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Reference encoder: greedy over Fibonacci weights, MSB first, leading bits sticky.
    function automatic logic [CW-1:0] model(input int din, input bit hen);
        int            r;
        logic [CW-1:0] c;
        bit            b;
        r = din;
        c = '0;
        for (int k = CW - 1; k >= 0; k--) begin
            if (k % 3 == 2) begin
                if (r < wt[k])                 b = 1'b0;
                else if (r >= wt[k] + wt[k-2]) b = 1'b1;
                else                           b = hen ? mh[k/3] : 1'b1;
                mh[k/3] = b;
            end else begin
                b = (r >= wt[k]);
            end
            c[k] = b;
            if (b) r = r - wt[k];
        end
        return c;
    endfunction

    always @(negedge clock) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid_hold", int'(out_valid), 1);
                chk("stall_code_hold", int'(code_out), int'(prev_code));
            end
            if (out_valid && !out_ready)
                chk("stall_in_ready", int'(in_ready), 0);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", int'(code_out), -1);
                end else begin
                    mon_it = sbq.pop_front();
                    chk("code", int'(code_out), int'(mon_it.exp));
                    wsum = 0;
                    for (int k = 0; k < CW; k++)
                        if (code_out[k]) wsum += wt[k];
                    chk("weighted_sum", wsum, mon_it.din);
                    if (mon_it.chk_lat)
                        chk("latency", cyc - mon_it.acc, 2);
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_code  = code_out;
        end
    end

    task automatic send(input int d, input bit hen, input bit use_exp,
                        input logic [CW-1:0] e, input bit lat);
        item_t it;
        int    n;
        it.exp = model(d, hen);
        if (use_exp) it.exp = e;
        it.din     = d;
        it.chk_lat = lat;
        in_data  = DW'(d);
        hys_en   = hen;
        in_valid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", int'(in_ready), 1);
            in_valid = 1'b0;
        end else begin
            it.acc = cyc + 1;
            sbq.push_back(it);
            @(posedge clock);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("drain", sbq.size(), 0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        wt[0] = 1;
        wt[1] = 2;
        for (int k = 2; k < CW; k++) wt[k] = wt[k-1] + wt[k-2];
        for (int g = 0; g < NG; g++) mh[g] = 1'b0;

        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        hys_en    = 1'b1;
        hys_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_code_out", int'(code_out), 0);
        rst_n = 1'b1;
        @(posedge clock);
        #1;

        send(3,  1, 1, 6'h03, 1);
        send(31, 1, 1, 6'h3E, 1);
        send(20, 1, 1, 6'h2A, 1);
        send(13, 1, 1, 6'h20, 1);
        send(13, 1, 1, 6'h20, 1);
        send(5,  1, 1, 6'h08, 1);
        send(13, 1, 1, 6'h18, 1);
        send(4,  1, 1, 6'h05, 1);
        send(3,  1, 1, 6'h04, 1);
        wait_drain();

        hys_clr = 1'b1;
        @(posedge clock);
        #1;
        hys_clr = 1'b0;
        for (int g = 0; g < NG; g++) mh[g] = 1'b0;
        send(3, 1, 1, 6'h03, 1);

        send(5,  0, 1, 6'h08, 1);
        send(13, 0, 1, 6'h20, 1);

        for (int v = 0; v < 32; v++) send(v, 1, 0, '0, 1);
        for (int v = 0; v < 32; v++) send(v, 0, 0, '0, 1);
        wait_drain();

        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(int'($urandom_range(0, 31)), 1'b1, 0, '0, 0);
            end
            begin
                n = 0;
                @(negedge clock);
                while (!out_valid && n < 50) begin
                    @(negedge clock);
                    n++;
                end
                chk("stall_fill", int'(out_valid), 1);
                repeat (3) @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        rdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    send(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0, '0, 0);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clock);
                        #1;
                    end
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clock);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        send(31, 1, 0, '0, 1);
        send(31, 1, 0, '0, 1);
        @(posedge clock);
        #1;
        chk("pre_reset_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", int'(out_valid), 0);
        chk("async_reset_code", int'(code_out), 0);
        chk("async_reset_in_ready", int'(in_ready), 1);
        sbq.delete();
        for (int g = 0; g < NG; g++) mh[g] = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        send(13, 1, 1, 6'h18, 1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
